// File: rtl/systolic_to_matrix_pkg.sv
// Shared definitions for the systolic drain path: FSM encoding and lane/counter helpers.
package systolic_to_matrix_pkg;

  // Job sequencer states; encoding is fixed so it can be observed on debug probes.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Low bit index of lane 'lane' inside a packed N*width bus.
  function automatic int lane_lo(input int lane, input int width);
    return lane * width;
  endfunction

  // Width of a counter that must be able to hold values 0..rows inclusive.
  function automatic int cnt_width(input int rows);
    int w;
    w = $clog2(rows + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/systolic_to_matrix_lane_delay.sv
// Fixed-depth shift register used to de-skew one result lane; DEPTH=0 degenerates to a wire.
module lane_delay #(
  parameter int W     = 32,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // The last lane is already aligned; clock and reset are deliberately unused here.
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n};
      assign dout      = din;
    end else begin : g_pipe
      logic [W-1:0] stage_reg [DEPTH];

      // Shift one stage per cycle; reset flushes every stage so nothing stale leaks out.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
          end
        end else begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_to_matrix.sv
// Drain side of the systolic array: de-skews N result lanes, packs each aligned row and
// writes it to result memory at BASE, BASE+1, ... until ROWS rows are stored, then pulses done.
module systolic_to_matrix
  import systolic_to_matrix_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 32,
  parameter int AW   = 5,
  parameter int ROWS = 4,
  parameter int BASE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  input  logic [N*W-1:0] in_data,
  output logic           wr_en,
  output logic [AW-1:0]  wr_addr,
  output logic [N*W-1:0] wr_data,
  output logic           busy,
  output logic           done
);

  localparam int CW = cnt_width(ROWS);
  localparam logic [CW-1:0] ROWS_C     = CW'(ROWS);
  localparam logic [CW-1:0] ROWS_LAST  = CW'(ROWS - 1);
  localparam logic [AW-1:0] BASE_ADDR  = AW'(BASE);

  state_t          state_reg;
  state_t          state_next;
  logic [CW-1:0]   acc_cnt_reg;
  logic [CW-1:0]   wr_cnt_reg;

  logic            accept;
  logic            start_ok;
  logic [N*W-1:0]  aligned_data;
  logic            aligned_valid;

  logic            wr_en_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic [N*W-1:0]  wr_data_reg;

  // A row is taken only while collecting and the job still needs rows.
  assign accept   = (state_reg == ST_COLLECT) && in_valid && (acc_cnt_reg < ROWS_C);
  // Re-arming is only legal once the previous job has fully drained.
  assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // Lane j arrives j cycles after lane 0, so it needs N-1-j stages to line up.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      lane_delay #(
        .W     (W),
        .DEPTH (N - 1 - gi)
      ) u_lane (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (in_data[lane_lo(gi, W) +: W]),
        .dout  (aligned_data[lane_lo(gi, W) +: W])
      );
    end
  endgenerate

  // The accept token follows the slowest (lane 0) path so it marks the aligned row.
  lane_delay #(
    .W     (1),
    .DEPTH (N - 1)
  ) u_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (accept),
    .dout  (aligned_valid)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: collect ROWS accepts, wait for the matching writes, pulse done.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (accept && (acc_cnt_reg == ROWS_LAST)) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (wr_cnt_reg == ROWS_C) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = start ? ST_COLLECT : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Accept and write counters; a fresh job clears both so addressing restarts at BASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
    end else if (start_ok) begin
      acc_cnt_reg <= '0;
      wr_cnt_reg  <= '0;
    end else begin
      if (accept) begin
        acc_cnt_reg <= acc_cnt_reg + CW'(1);
      end
      if (aligned_valid) begin
        wr_cnt_reg <= wr_cnt_reg + CW'(1);
      end
    end
  end

  // Output register: one write per aligned row; address and data hold between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= BASE_ADDR;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= aligned_valid;
      if (aligned_valid) begin
        // Address arithmetic is modulo 2**AW by truncation.
        wr_addr_reg <= BASE_ADDR + AW'(wr_cnt_reg);
        wr_data_reg <= aligned_data;
      end
    end
  end

  assign wr_en   = wr_en_reg;
  assign wr_addr = wr_addr_reg;
  assign wr_data = wr_data_reg;
  assign busy    = (state_reg == ST_COLLECT) || (state_reg == ST_FLUSH);
  assign done    = (state_reg == ST_DONE);

endmodule

// File: tb/tb_systolic_to_matrix.sv
// Scoreboard bench: two instances (BASE=0 and BASE=30) share one skewed stimulus stream.
`timescale 1ns/1ps
module tb_systolic_to_matrix;

  localparam int N      = 4;
  localparam int W      = 32;
  localparam int AW     = 5;
  localparam int ROWS   = 4;
  localparam int BASE_A = 0;
  localparam int BASE_B = 30;
  localparam int MAXC   = 2048;

  logic           clk      = 1'b0;
  logic           rst_n    = 1'b1;
  logic           start    = 1'b0;
  logic           in_valid = 1'b0;
  logic [N*W-1:0] in_data  = '0;

  logic           wr_en_a, wr_en_b;
  logic [AW-1:0]  wr_addr_a, wr_addr_b;
  logic [N*W-1:0] wr_data_a, wr_data_b;
  logic           busy_a, busy_b, done_a, done_b;

  systolic_to_matrix #(.N(N), .W(W), .AW(AW), .ROWS(ROWS), .BASE(BASE_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .busy(busy_a), .done(done_a)
  );

  systolic_to_matrix #(.N(N), .W(W), .AW(AW), .ROWS(ROWS), .BASE(BASE_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b), .done(done_b)
  );

  always #5 clk = ~clk;

  // Cycle c is the period after posedge c; inputs set at its negedge are sampled at its end.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit           valid_at [MAXC];
  logic [W-1:0] lane_at  [MAXC][N];

  typedef struct {
    int             cyc;
    logic [N*W-1:0] data;
    int             idx;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Skewed driver: lane j in cycle c carries the row whose lane-0 cycle was c-j, else noise.
  int src;
  always @(negedge clk) begin
    in_valid = (cyc < MAXC) ? valid_at[cyc] : 1'b0;
    for (int j = 0; j < N; j++) begin
      src = cyc - j;
      if (src >= 0 && src < MAXC && valid_at[src]) in_data[j*W +: W] = lane_at[src][j];
      else                                          in_data[j*W +: W] = $urandom;
    end
  end

  // Write monitor: each write pops the scoreboard and is checked on both instances.
  exp_t          e_mon;
  logic [AW-1:0] ea, eb;
  always @(negedge clk) begin
    if (wr_en_a || wr_en_b) begin
      n_checks++;
      if (wr_en_a !== wr_en_b) $display("FAIL wr_en_pair cyc=%0d got a=%b b=%b exp equal", cyc, wr_en_a, wr_en_b);
      else n_pass++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write cyc=%0d got addr=%0d exp no write", cyc, wr_addr_a);
      end else begin
        n_pass++;
        e_mon = exp_q.pop_front();
        ea = AW'(BASE_A + e_mon.idx);
        eb = AW'(BASE_B + e_mon.idx);
        $display("write cyc=%0d idx=%0d addr_a=%0d addr_b=%0d data=%h", cyc, e_mon.idx, wr_addr_a, wr_addr_b, wr_data_a);
        n_checks++;
        if (cyc !== e_mon.cyc) $display("FAIL write_cycle got=%0d exp=%0d", cyc, e_mon.cyc);
        else n_pass++;
        n_checks++;
        if (wr_addr_a !== ea) $display("FAIL addr_a got=%0d exp=%0d", wr_addr_a, ea);
        else n_pass++;
        n_checks++;
        if (wr_addr_b !== eb) $display("FAIL addr_b got=%0d exp=%0d", wr_addr_b, eb);
        else n_pass++;
        n_checks++;
        if (wr_data_a !== e_mon.data) $display("FAIL data_a got=%h exp=%h", wr_data_a, e_mon.data);
        else n_pass++;
        n_checks++;
        if (wr_data_b !== e_mon.data) $display("FAIL data_b got=%h exp=%h", wr_data_b, e_mon.data);
        else n_pass++;
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      n_checks++;
      e_mon = exp_q.pop_front();
      $display("FAIL missed_write cyc=%0d got wr_en=0 exp write idx=%0d at cyc=%0d", cyc, e_mon.idx, e_mon.cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp $finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_job();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Schedule a row whose lane 0 appears in cycle t; optionally expect its write at t+N.
  task automatic sched_row(input int t, input bit exp_wr, input int idx, input bit fixed);
    logic [N*W-1:0] d;
    for (int j = 0; j < N; j++) begin
      lane_at[t][j] = fixed ? (32'h10 + 32'(j)) : 32'($urandom);
      d[j*W +: W]   = lane_at[t][j];
    end
    valid_at[t] = 1'b1;
    if (exp_wr) exp_q.push_back('{t + N, d, idx});
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (wr_en_a !== 1'b0) $display("FAIL rst_wr_en got=%b exp=0", wr_en_a); else n_pass++;
    n_checks++; if (wr_addr_a !== AW'(BASE_A)) $display("FAIL rst_addr_a got=%0d exp=%0d", wr_addr_a, BASE_A); else n_pass++;
    n_checks++; if (wr_addr_b !== AW'(BASE_B)) $display("FAIL rst_addr_b got=%0d exp=%0d", wr_addr_b, BASE_B); else n_pass++;
    n_checks++; if (wr_data_a !== '0) $display("FAIL rst_data got=%h exp=0", wr_data_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL rst_busy_done got=%b%b exp=00", busy_a, done_a); else n_pass++;
    rst_n = 1'b1;
    // A row presented while idle must never be written.
    sched_row(cyc + 2, 1'b0, 0, 1'b0);
    wait_until(cyc + 12);
    n_checks++; if (busy_a !== 1'b0) $display("FAIL idle_in_valid_busy got=%b exp=0", busy_a); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single_row();
    int t;
    logic [N*W-1:0] exp_d;
    start_job();
    t = cyc + 2;
    sched_row(t, 1'b1, 0, 1'b1);
    for (int j = 0; j < N; j++) exp_d[j*W +: W] = 32'h10 + 32'(j);
    wait_until(t + N - 1);
    n_checks++; if (wr_en_a !== 1'b0) $display("FAIL single_early got wr_en=%b exp=0", wr_en_a); else n_pass++;
    wait_until(t + N);
    n_checks++; if (wr_en_a !== 1'b1) $display("FAIL single_wr_en got=%b exp=1", wr_en_a); else n_pass++;
    n_checks++; if (wr_data_a !== exp_d) $display("FAIL single_data got=%h exp=%h", wr_data_a, exp_d); else n_pass++;
    wait_until(t + N + 1);
    n_checks++; if (wr_en_a !== 1'b0 || wr_addr_a !== AW'(BASE_A)) $display("FAIL single_hold got en=%b addr=%0d exp en=0 addr=%0d", wr_en_a, wr_addr_a, BASE_A); else n_pass++;
    n_checks++; if (busy_a !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy_a); else n_pass++;
    apply_reset();
    $display("test_single_row done");
  endtask

  task automatic test_back_to_back();
    int t, last;
    start_job();
    t = cyc + 2;
    for (int k = 0; k < ROWS; k++) sched_row(t + k, 1'b1, k, 1'b0);
    last = t + ROWS - 1;
    wait_until(last + N);
    n_checks++; if (busy_a !== 1'b1 || done_a !== 1'b0) $display("FAIL b2b_last_write got busy=%b done=%b exp 1 0", busy_a, done_a); else n_pass++;
    wait_until(last + N + 1);
    n_checks++; if (done_a !== 1'b1 || busy_a !== 1'b0) $display("FAIL b2b_done got done=%b busy=%b exp 1 0", done_a, busy_a); else n_pass++;
    wait_until(last + N + 2);
    n_checks++; if (done_a !== 1'b0 || busy_a !== 1'b0) $display("FAIL b2b_after got done=%b busy=%b exp 0 0", done_a, busy_a); else n_pass++;
    $display("test_back_to_back done");
  endtask

  task automatic test_bubbles();
    int t;
    int offs [4] = '{0, 3, 4, 9};
    start_job();
    t = cyc + 2;
    for (int k = 0; k < ROWS; k++) sched_row(t + offs[k], 1'b1, k, 1'b0);
    sched_row(t + 11, 1'b0, 0, 1'b0);
    wait_until(t + 9 + N + 1);
    n_checks++; if (done_a !== 1'b1) $display("FAIL bubbles_done got=%b exp=1", done_a); else n_pass++;
    wait_until(cyc + 1);
    sched_row(cyc + 2, 1'b0, 0, 1'b0);
    wait_until(cyc + 12);
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL bubbles_idle got busy=%b done=%b exp 0 0", busy_a, done_a); else n_pass++;
    $display("test_bubbles done");
  endtask

  task automatic test_restart_wrap();
    int t, d, t2;
    start_job();
    t = cyc + 2;
    for (int k = 0; k < ROWS; k++) sched_row(t + k, 1'b1, k, 1'b0);
    d = t + ROWS - 1 + N + 1;
    wait_until(d);
    n_checks++; if (done_a !== 1'b1) $display("FAIL restart_done1 got=%b exp=1", done_a); else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) $display("FAIL restart_busy got a=%b b=%b exp 1 1", busy_a, busy_b); else n_pass++;
    t2 = cyc + 2;
    for (int k = 0; k < ROWS; k++) sched_row(t2 + k, 1'b1, k, 1'b0);
    wait_until(t2 + 2 + N);
    n_checks++; if (wr_addr_b !== AW'(0)) $display("FAIL wrap_addr got=%0d exp=0", wr_addr_b); else n_pass++;
    wait_until(t2 + ROWS - 1 + N + 1);
    n_checks++; if (done_b !== 1'b1) $display("FAIL restart_done2 got=%b exp=1", done_b); else n_pass++;
    $display("test_restart_wrap done");
  endtask

  task automatic test_start_while_busy();
    int t, ndone, dcyc;
    start_job();
    t = cyc + 2;
    for (int k = 0; k < ROWS; k++) sched_row(t + k, 1'b1, k, 1'b0);
    wait_until(t + 5);
    n_checks++; if (busy_a !== 1'b1) $display("FAIL swb_in_flush got busy=%b exp=1", busy_a); else n_pass++;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dcyc  = -1;
    for (int c = t + 6; c < t + ROWS - 1 + N + 14; c++) begin
      wait_until(c);
      if (done_a === 1'b1) begin
        ndone++;
        dcyc = c;
      end
    end
    n_checks++; if (ndone !== 1) $display("FAIL swb_done_count got=%0d exp=1", ndone); else n_pass++;
    n_checks++; if (dcyc !== t + ROWS - 1 + N + 1) $display("FAIL swb_done_cycle got=%0d exp=%0d", dcyc, t + ROWS - 1 + N + 1); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL swb_idle got busy=%b exp=0", busy_a); else n_pass++;
    $display("test_start_while_busy done");
  endtask

  task automatic test_reset_mid_job();
    int t;
    start_job();
    t = cyc + 2;
    for (int k = 0; k < ROWS; k++) sched_row(t + k, 1'b0, k, 1'b0);
    wait_until(t + 2);
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL mid_rst_busy got busy=%b done=%b exp 0 0", busy_a, done_a); else n_pass++;
    n_checks++; if (wr_en_a !== 1'b0 || wr_addr_b !== AW'(BASE_B) || wr_data_a !== '0) $display("FAIL mid_rst_outputs got en=%b addr=%0d data=%h exp 0 %0d 0", wr_en_a, wr_addr_b, wr_data_a, BASE_B); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    wait_until(cyc + 15);
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) $display("FAIL mid_rst_after got busy=%b done=%b exp 0 0", busy_a, done_a); else n_pass++;
    $display("test_reset_mid_job done");
  endtask

  initial begin
    test_reset();
    test_single_row();
    test_back_to_back();
    test_bubbles();
    test_restart_wrap();
    test_start_while_busy();
    test_reset_mid_job();
    wait_until(cyc + 4);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_empty got=%0d exp=0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
